// File: rtl/pipelined_adder.sv
// Pipelined WIDTH-bit add/subtract, STAGES carry-chained chunks with a global-stall valid/ready pipe.
// Optional signed-overflow output is built when PIPELINED_ADDER_OVERFLOW_EN is defined.
module pipelined_adder #(
    parameter int WIDTH  = 32,
    parameter int STAGES = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic             sub,
    input  logic [WIDTH-1:0] data_in1,
    input  logic [WIDTH-1:0] data_in2,
    input  logic             Cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] data_out,
    output logic             Cout,
    output logic             ovf
);

    localparam int CW = WIDTH / STAGES;

    logic [STAGES-1:0] valid_q;
    logic [STAGES-1:0] carry_q;
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  sum_q [STAGES];

    logic [STAGES-1:0] v_in;
    logic [STAGES-1:0] c_in;
    logic [STAGES-1:0] c_nxt;
    logic [WIDTH-1:0]  a_in  [STAGES];
    logic [WIDTH-1:0]  b_in  [STAGES];
    logic [WIDTH-1:0]  s_in  [STAGES];
    logic [WIDTH-1:0]  s_nxt [STAGES];
    logic [CW:0]       part  [STAGES];
    logic              adv;

    // Global stall: the whole pipe moves only when the last slot can drain.
    assign adv      = ~out_valid | out_ready;
    assign in_ready = adv;

    // Stage 0 sees the conditioned operands; stage k sees the registers of stage k-1.
    always_comb begin
        v_in[0] = in_valid;
        a_in[0] = data_in1;
        b_in[0] = sub ? ~data_in2 : data_in2;
        c_in[0] = sub ? ~Cin : Cin;
        s_in[0] = '0;
        for (int k = 1; k < STAGES; k++) begin
            v_in[k] = valid_q[k-1];
            a_in[k] = a_q[k-1];
            b_in[k] = b_q[k-1];
            c_in[k] = carry_q[k-1];
            s_in[k] = sum_q[k-1];
        end
    end

    always_comb begin
        for (int k = 0; k < STAGES; k++) begin
            part[k]  = {1'b0, a_in[k][k*CW +: CW]} + {1'b0, b_in[k][k*CW +: CW]}
                     + {{CW{1'b0}}, c_in[k]};
            s_nxt[k] = s_in[k];
            s_nxt[k][k*CW +: CW] = part[k][CW-1:0];
            c_nxt[k] = part[k][CW];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q <= '0;
            carry_q <= '0;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                sum_q[k] <= '0;
            end
        end else if (adv) begin
            valid_q <= v_in;
            carry_q <= c_nxt;
            for (int k = 0; k < STAGES; k++) begin
                a_q[k]   <= a_in[k];
                b_q[k]   <= b_in[k];
                sum_q[k] <= s_nxt[k];
            end
        end
    end

    assign out_valid = valid_q[STAGES-1];
    assign data_out  = sum_q[STAGES-1];
    assign Cout      = carry_q[STAGES-1];

`ifdef PIPELINED_ADDER_OVERFLOW_EN
    logic msb_cin;
    logic ovf_q;

    // Carry into the MSB is recovered from the MSB sum bit and its two operand bits.
    assign msb_cin = a_in[STAGES-1][WIDTH-1] ^ b_in[STAGES-1][WIDTH-1]
                   ^ s_nxt[STAGES-1][WIDTH-1];

    always_ff @(posedge clk) begin
        if (reset) begin
            ovf_q <= 1'b0;
        end else if (adv) begin
            ovf_q <= msb_cin ^ c_nxt[STAGES-1];
        end
    end

    assign ovf = ovf_q;
`else
    assign ovf = 1'b0;
`endif

endmodule
